// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded T-state sequencer for the 4-bit bus CPU
module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic                pc_ce,
    output logic                pc_oe,
    output logic                pc_ie,
    output logic                mar_ie,
    output logic                ram_oe,
    output logic                ram_we,
    output logic                ir_ie,
    output logic                ir_oe,
    output logic                a_ie,
    output logic                a_oe,
    output logic                b_ie,
    output logic                alu_oe,
    output logic                alu_sub,
    output logic                flags_ie,
    output logic                out_ie,
    output logic                hlt,
    output logic                instr_done,
    output logic [STEP_W-1:0]   step
);

    typedef enum logic [STEP_W-1:0] {
        T0 = STEP_W'(0),
        T1 = STEP_W'(1),
        T2 = STEP_W'(2),
        T3 = STEP_W'(3),
        T4 = STEP_W'(4)
    } step_t;

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    step_t step_q, step_d;
    logic  halted_q, halted_d;
    logic  run;
    logic  last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // Reset gates the enables combinationally so nothing leaks while it is held.
    assign run  = reset & enable & ~halted_q;
    assign hlt  = halted_q;
    assign step = step_q;

    always_comb begin
        step_d     = step_q;
        halted_d   = halted_q;
        last       = 1'b0;
        pc_ce      = 1'b0;
        pc_oe      = 1'b0;
        pc_ie      = 1'b0;
        mar_ie     = 1'b0;
        ram_oe     = 1'b0;
        ram_we     = 1'b0;
        ir_ie      = 1'b0;
        ir_oe      = 1'b0;
        a_ie       = 1'b0;
        a_oe       = 1'b0;
        b_ie       = 1'b0;
        alu_oe     = 1'b0;
        alu_sub    = 1'b0;
        flags_ie   = 1'b0;
        out_ie     = 1'b0;
        instr_done = 1'b0;

        if (run) begin
            case (step_q)
                T0: begin
                    pc_oe  = 1'b1;
                    mar_ie = 1'b1;
                    step_d = T1;
                end
                T1: begin
                    ram_oe = 1'b1;
                    ir_ie  = 1'b1;
                    pc_ce  = 1'b1;
                    step_d = T2;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_oe  = 1'b1;
                            mar_ie = 1'b1;
                            step_d = T3;
                        end
                        OP_LDI: begin
                            ir_oe = 1'b1;
                            a_ie  = 1'b1;
                            last  = 1'b1;
                        end
                        OP_JMP: begin
                            ir_oe = 1'b1;
                            pc_ie = 1'b1;
                            last  = 1'b1;
                        end
                        OP_JC: begin
                            ir_oe = carry_flag;
                            pc_ie = carry_flag;
                            last  = 1'b1;
                        end
                        OP_JZ: begin
                            ir_oe = zero_flag;
                            pc_ie = zero_flag;
                            last  = 1'b1;
                        end
                        OP_OUT: begin
                            a_oe   = 1'b1;
                            out_ie = 1'b1;
                            last   = 1'b1;
                        end
                        OP_HLT: begin
                            halted_d = 1'b1;
                            last     = 1'b1;
                        end
                        default: last = 1'b1;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_oe = 1'b1;
                            a_ie   = 1'b1;
                            last   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_oe = 1'b1;
                            b_ie   = 1'b1;
                            step_d = T4;
                        end
                        OP_STA: begin
                            a_oe   = 1'b1;
                            ram_we = 1'b1;
                            last   = 1'b1;
                        end
                        default: last = 1'b1;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_oe   = 1'b1;
                        a_ie     = 1'b1;
                        flags_ie = 1'b1;
                        alu_sub  = (opcode == OP_SUB);
                    end
                    last = 1'b1;
                end
                default: step_d = T0;
            endcase
        end else if (step_q > T4) begin
            step_d = T0;
        end

        if (last) begin
            instr_done = 1'b1;
            step_d     = T0;
        end
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 4-bit bus CPU.
- Owns the T-state step counter, decodes the IR opcode and the ALU flags, and emits every enable the datapath uses:
  - program counter: counter_enable, output_enable, input_enable
  - MAR, RAM, IR, A, B, ALU, flags, OUT
- Guarantees at most one bus driver per cycle.
- Datapath registers capture on the posedge that ends the T-state in which their enable is high.

Parameters:
- OPCODE_W, 4, width of opcode field from IR upper nibble.
- STEP_W, 3, width of step counter (steps T0..T4 used).

Ports:
- clk  input  1  system clock, all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run enable; low = freeze sequencer.
- opcode  input  OPCODE_W  IR[7:4], valid from T2 onward.
- carry_flag  input  1  registered ALU carry flag.
- zero_flag  input  1  registered ALU zero flag.
- pc_ce  output  1  program counter counter_enable.
- pc_oe  output  1  program counter output_enable (drives bus).
- pc_ie  output  1  program counter input_enable (load from bus).
- mar_ie  output  1  MAR load.
- ram_oe  output  1  RAM drives bus.
- ram_we  output  1  RAM write from bus.
- ir_ie  output  1  IR load.
- ir_oe  output  1  IR operand nibble drives bus.
- a_ie  output  1  A register load.
- a_oe  output  1  A register drives bus.
- b_ie  output  1  B register load.
- alu_oe  output  1  ALU result drives bus.
- alu_sub  output  1  ALU subtract select.
- flags_ie  output  1  flags register load.
- out_ie  output  1  output register load.
- hlt  output  1  CPU halted (registered).
- instr_done  output  1  high during the final step of each instruction.
- step  output  STEP_W  current T-state, debug/verification.

Behaviour:
- State: step register (0..4) plus halted bit. Reset (reset=0, async): step=0, halted=0, all control outputs 0 while reset is held.
- Control outputs are combinational from (step, opcode, flags, enable, halted). Step and halted are registered.
- Fetch (all opcodes):
  - T0: pc_oe, mar_ie.
  - T1: ram_oe, ir_ie, pc_ce.
  - T1 always advances to T2.
- Execute (T2+), opcode -> micro-steps; last listed step asserts instr_done, and the next step is T0:
  - 0x0 NOP: T2 none.
  - 0x1 LDA: T2 ir_oe,mar_ie; T3 ram_oe,a_ie.
  - 0x2 ADD: T2 ir_oe,mar_ie; T3 ram_oe,b_ie; T4 alu_oe,a_ie,flags_ie.
  - 0x3 SUB: as ADD, with alu_sub high in T4.
  - 0x4 STA: T2 ir_oe,mar_ie; T3 a_oe,ram_we.
  - 0x5 LDI: T2 ir_oe,a_ie.
  - 0x6 JMP: T2 ir_oe,pc_ie.
  - 0x7 JC: T2 ir_oe,pc_ie only if carry_flag=1, else no enables.
  - 0x8 JZ: T2 ir_oe,pc_ie only if zero_flag=1, else no enables.
  - 0xE OUT: T2 a_oe,out_ie.
  - 0xF HLT: T2 no enables, instr_done=1; next edge sets halted=1.
  - Undefined opcodes (0x9-0xD) behave as NOP.
- Instruction lengths: NOP/LDI/JMP/JC/JZ/OUT/HLT = 3 cycles; LDA/STA = 4; ADD/SUB = 5.
- Halted: hlt=1; step holds at 0; every other output 0. Only reset exits.
- enable=0: step and halted hold; all enables and instr_done forced 0; hlt still reflects halted. Resumes at the same step when enable returns to 1.
- Invariants: at most one of pc_oe, ram_oe, ir_oe, a_oe, alu_oe is high in any cycle. pc_ce and pc_ie are never high together. Step never exceeds 4. A step value of 5..7 is unreachable; if it occurs, the next step is 0.
- Reset asserted mid-instruction: immediate return to T0/no enables; no partial micro-step completes.

Test Plan:
- Reset release, enable=1, opcode=0x5 -> step sequence 0,1,2,0; T0 pc_oe=mar_ie=1; T1 ram_oe=ir_ie=pc_ce=1; T2 ir_oe=a_ie=1, instr_done=1.
- opcode=0x2, then 0x3 -> step 0..4; T4 alu_oe=a_ie=flags_ie=1, alu_sub=0 for ADD and 1 for SUB; 5 cycles each; instr_done only in T4.
- opcode=0x7 with carry_flag=0, then carry_flag=1 -> T2 pc_ie=0, then pc_ie=ir_oe=1; both return to T0 after T2.
- opcode=0xF -> instr_done at T2; from the next cycle hlt=1, step=0, all enables 0 for 20 cycles; reset low->high clears hlt.
- ADD: drop enable at T3 for 3 cycles -> step holds at 3, outputs 0; restore enable -> T3 enables (ram_oe,b_ie) reappear, then T4.
- Assert reset during ADD T3 (asynchronous, mid-cycle) -> step=0 and all outputs 0 immediately; random-opcode run of 1000 instructions never shows two bus drivers active in one cycle.
